// File: rtl/fetch_unit.sv
// fetch_unit -- instruction-fetch front end for the 16-bit WISC CPU.
//
// Owns the architectural fetch PC, issues one-at-a-time word reads to a
// variable-latency instruction memory, buffers returned instructions together
// with their PCs, and hands them to decode. Branch redirects flush everything
// younger than the branch; an accepted HLT stops fetch until reset.
//
// Configuration macro: FETCH_PREFETCH_BUF_EN
//   defined     -> two-entry buffer; the next fetch may be issued while one
//                  instruction waits, including back-to-back on ack.
//   not defined -> one-entry buffer; a request issues only when the buffer is
//                  empty or being popped this cycle.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   imem_req, imem_addr   registered read request / byte address (bit0 = 0)
//   imem_rdata, imem_ack  returned word and its one-cycle completion strobe
//   if_valid, if_instr,   buffer head towards decode
//   if_pc, id_ready
//   redirect_valid,       taken-branch redirect; bit0 of redirect_pc ignored
//   redirect_pc
//   hlt                   sticky, set the cycle after decode accepts HLT
//   pc                    address of the next request to issue
//
// Handshakes:
//   decode side: an instruction moves when if_valid & id_ready are both high
//   at a rising edge; if_valid never depends on id_ready.
//   memory side: imem_req/imem_addr stay stable from issue until the cycle
//   carrying imem_ack; requests already at the memory are never withdrawn.

module fetch_unit (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  output logic        hlt,
  output logic [15:0] pc
);

`ifdef FETCH_PREFETCH_BUF_EN
  localparam logic [1:0] DEPTH = 2'd2;
`else
  localparam logic [1:0] DEPTH = 2'd1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP, S_HALT} state_t;

  state_t      state_q, state_d;
  logic        req_d;
  logic [15:0] addr_d;
  logic [15:0] fetch_pc_q, fetch_pc_d;
  logic        hlt_d;

  // Shift-register FIFO: entry 0 is always the head.
  logic [15:0] b0_pc, b0_instr, b1_pc, b1_instr;
  logic [15:0] n_b0_pc, n_b0_instr, n_b1_pc, n_b1_instr;
  logic [1:0]  count_q, count_d;

  logic        redirect;
  logic        pop;
  logic        push;
  logic        flush;
  logic [1:0]  cnt_after_pop;
  logic [15:0] redirect_tgt;
  logic [15:0] next_seq_pc;
  logic        ack_is_hlt;

  // Once hlt is set, redirects are ignored entirely.
  assign redirect      = redirect_valid & ~hlt;
  assign if_valid      = (count_q != 2'd0) & ~redirect_valid & ~hlt;
  assign pop           = if_valid & id_ready;
  assign cnt_after_pop = count_q - {1'b0, pop};
  assign redirect_tgt  = redirect_pc & 16'hFFFE;
  assign next_seq_pc   = fetch_pc_q + 16'd2;
  assign ack_is_hlt    = (imem_rdata[15:12] == 4'hF);

  assign if_instr = b0_instr;
  assign if_pc    = b0_pc;
  assign pc       = fetch_pc_q;

  // Next-state / request logic.
  always_comb begin
    state_d    = state_q;
    req_d      = imem_req;
    addr_d     = imem_addr;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    flush      = 1'b0;
    hlt_d      = hlt | (pop & (b0_instr[15:12] == 4'hF));
    case (state_q)
      S_IDLE, S_HALT: begin
        // No request outstanding: a redirect is fetched on the next edge.
        // HALT only leaves through a redirect (the HLT was speculative).
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_tgt;
          req_d      = 1'b1;
          addr_d     = redirect_tgt;
          state_d    = S_WAIT;
        end else if (state_q == S_IDLE && cnt_after_pop < DEPTH) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_tgt;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end else begin
            // Request stays at the memory; its data will be thrown away.
            state_d = S_DROP;
          end
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = next_seq_pc;
          if (ack_is_hlt) begin
            req_d   = 1'b0;
            state_d = S_HALT;
          end else if (cnt_after_pop + 2'd1 < DEPTH) begin
            addr_d = next_seq_pc;
          end else begin
            req_d   = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect) begin
          flush      = 1'b1;
          fetch_pc_d = redirect_tgt;
        end
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer update: pop shifts entry 1 forward, push lands behind the
  // surviving entries.
  always_comb begin
    n_b0_pc    = b0_pc;
    n_b0_instr = b0_instr;
    n_b1_pc    = b1_pc;
    n_b1_instr = b1_instr;
    count_d    = count_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        n_b0_pc    = b1_pc;
        n_b0_instr = b1_instr;
      end
      count_d = cnt_after_pop;
      if (push) begin
        if (cnt_after_pop == 2'd0) begin
          n_b0_pc    = imem_addr;
          n_b0_instr = imem_rdata;
        end else begin
          n_b1_pc    = imem_addr;
          n_b1_instr = imem_rdata;
        end
        count_d = cnt_after_pop + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      imem_req   <= 1'b0;
      imem_addr  <= 16'h0000;
      fetch_pc_q <= 16'h0000;
      hlt        <= 1'b0;
      count_q    <= 2'd0;
      b0_pc      <= 16'h0000;
      b0_instr   <= 16'h0000;
      b1_pc      <= 16'h0000;
      b1_instr   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      imem_req   <= req_d;
      imem_addr  <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      hlt        <= hlt_d;
      count_q    <= count_d;
      b0_pc      <= n_b0_pc;
      b0_instr   <= n_b0_instr;
      b1_pc      <= n_b1_pc;
      b1_instr   <= n_b1_instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- directed bench for fetch_unit with a latency-programmable
// instruction memory responder and a decode-side delivery monitor.
// Inputs change just after the falling edge; outputs are sampled there too.

module tb_fetch_unit;

`ifdef FETCH_PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        id_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        hlt;
  logic [15:0] pc;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .hlt(hlt), .pc(pc)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int ack_lat = 0;
  int budget  = 0;
  int lat_cnt = 0;

  logic [15:0] mem [0:32767];
  logic [15:0] got_pc[$];
  logic [15:0] got_instr[$];
  logic [31:0] exp_q[$];

  // ---------------- memory responder ----------------
  // Acks a request after ack_lat extra cycles, while budget lasts.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req && budget > 0) begin
        if (lat_cnt >= ack_lat) begin
          imem_ack   = 1'b1;
          imem_rdata = mem[imem_addr[15:1]];
          lat_cnt    = 0;
          budget     = budget - 1;
        end else begin
          imem_ack = 1'b0;
          lat_cnt  = lat_cnt + 1;
        end
      end else begin
        imem_ack = 1'b0;
        lat_cnt  = 0;
      end
    end
  end

  // ---------------- delivery monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && if_valid && id_ready) begin
        got_pc.push_back(if_pc);
        got_instr.push_back(if_instr);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Leaves rst_n high just before the first rising edge of the new run.
  task automatic apply_reset(input int lat, input int bud, input logic rdy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 16'h0000;
    id_ready       = 1'b0;
    budget         = 0;
    repeat (2) cyc();
    got_pc.delete();
    got_instr.delete();
    ack_lat  = lat;
    budget   = bud;
    id_ready = rdy;
    rst_n    = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n  = 1'b0;
    budget = 0;
    repeat (3) cyc();
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL reset_imem_req got=%0b exp=0", imem_req); end
    n_checks++; if (imem_addr !== 16'h0) begin n_errors++; $display("FAIL reset_imem_addr got=%h exp=0000", imem_addr); end
    n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL reset_if_valid got=%0b exp=0", if_valid); end
    n_checks++; if (if_instr !== 16'h0) begin n_errors++; $display("FAIL reset_if_instr got=%h exp=0000", if_instr); end
    n_checks++; if (if_pc !== 16'h0) begin n_errors++; $display("FAIL reset_if_pc got=%h exp=0000", if_pc); end
    n_checks++; if (hlt !== 1'b0) begin n_errors++; $display("FAIL reset_hlt got=%0b exp=0", hlt); end
    n_checks++; if (pc !== 16'h0) begin n_errors++; $display("FAIL reset_pc got=%h exp=0000", pc); end
    rst_n = 1'b1;
    cyc();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_errors++; $display("FAIL first_request got req=%0b addr=%h exp req=1 addr=0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    mem[0] = 16'h1123;
    mem[1] = 16'h2456;
    apply_reset(0, 2, 1'b1);
    cyc();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_errors++; $display("FAIL stream_req0 got req=%0b addr=%h exp req=1 addr=0000", imem_req, imem_addr);
    end
    cyc();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000 || if_instr !== 16'h1123) begin
      n_errors++; $display("FAIL stream_head0 got v=%0b pc=%h instr=%h exp v=1 pc=0000 instr=1123", if_valid, if_pc, if_instr);
    end
`ifndef FETCH_PREFETCH_BUF_EN
    cyc();
    n_checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
      n_errors++; $display("FAIL stream_gap got v=%0b req=%0b addr=%h exp v=0 req=1 addr=0002", if_valid, imem_req, imem_addr);
    end
`endif
    cyc();
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0002 || if_instr !== 16'h2456) begin
      n_errors++; $display("FAIL stream_head1 got v=%0b pc=%h instr=%h exp v=1 pc=0002 instr=2456", if_valid, if_pc, if_instr);
    end
    repeat (4) cyc();
    n_checks++; if (pc !== 16'h0004) begin n_errors++; $display("FAIL stream_pc got=%h exp=0004", pc); end
    n_checks++; if (got_pc.size() != 2 || got_pc[0] !== 16'h0000 || got_pc[1] !== 16'h0002) begin
      n_errors++; $display("FAIL stream_delivered got n=%0d exp n=2 pcs 0000,0002", got_pc.size());
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] a;
    apply_reset(3, 10, 1'b0);
    repeat (30) cyc();
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL bp_req_dropped got=%0b exp=0", imem_req); end
    n_checks++; if (pc !== 16'(2 * DEPTH)) begin n_errors++; $display("FAIL bp_pc got=%h exp=%h", pc, 16'(2 * DEPTH)); end
    n_checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0000) begin
      n_errors++; $display("FAIL bp_head got v=%0b pc=%h exp v=1 pc=0000", if_valid, if_pc);
    end
    n_checks++; if (got_pc.size() != 0) begin n_errors++; $display("FAIL bp_no_delivery got n=%0d exp 0", got_pc.size()); end
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      a = 16'(2 * i);
      exp_q.push_back({a, mem[a[15:1]]});
    end
    id_ready = 1'b1;
    repeat (100) cyc();
    n_checks++; if (got_pc.size() != exp_q.size()) begin
      n_errors++; $display("FAIL bp_count got=%0d exp=%0d", got_pc.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_pc.size(); i++) begin
      n_checks++; if ({got_pc[i], got_instr[i]} !== exp_q[i]) begin
        n_errors++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, {got_pc[i], got_instr[i]}, exp_q[i]);
      end
    end
  endtask

  task automatic test_redirect_outstanding();
    int s0;
    int held;
    bit found;
    bit seen6;
    apply_reset(3, 100, 1'b1);
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cyc();
      if (imem_req && imem_addr == 16'h0006) found = 1;
    end
    n_checks++; if (!found) begin n_errors++; $display("FAIL redir_find_req6 got timeout exp request at 0006"); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0041;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL redir_if_valid got=%0b exp=0", if_valid); end
    s0 = got_pc.size();
    cyc();
    redirect_valid = 1'b0;
    n_checks++; if (pc !== 16'h0040) begin n_errors++; $display("FAIL redir_pc got=%h exp=0040", pc); end
    held = 0;
    while (held < 20 && imem_req && imem_addr == 16'h0006) begin
      held++;
      cyc();
    end
    n_checks++; if (held != 3) begin n_errors++; $display("FAIL redir_addr_hold got=%0d cycles exp=3", held); end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req) found = 1;
      else cyc();
    end
    n_checks++; if (!found || imem_addr !== 16'h0040) begin
      n_errors++; $display("FAIL redir_new_addr got req=%0b addr=%h exp req=1 addr=0040", imem_req, imem_addr);
    end
    repeat (20) cyc();
    n_checks++; if (got_pc.size() <= s0 || got_pc[s0] !== 16'h0040 || got_instr[s0] !== mem[16'h0020]) begin
      n_errors++; $display("FAIL redir_first_after got n=%0d exp pc=0040 at index %0d", got_pc.size(), s0);
    end
    seen6 = 0;
    foreach (got_pc[i]) if (got_pc[i] == 16'h0006) seen6 = 1;
    n_checks++; if (seen6) begin n_errors++; $display("FAIL redir_squashed got pc 0006 delivered exp never"); end
  endtask

  task automatic test_halt();
    bit found;
    mem[8] = 16'hF000;
    apply_reset(0, 100, 1'b1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc();
      if (if_valid && if_pc == 16'h0010) found = 1;
    end
    n_checks++; if (!found || if_instr !== 16'hF000 || hlt !== 1'b0) begin
      n_errors++; $display("FAIL halt_head got found=%0b instr=%h hlt=%0b exp found=1 instr=F000 hlt=0", found, if_instr, hlt);
    end
    cyc();
    n_checks++; if (hlt !== 1'b1 || if_valid !== 1'b0) begin
      n_errors++; $display("FAIL halt_set got hlt=%0b v=%0b exp hlt=1 v=0", hlt, if_valid);
    end
    n_checks++; if (pc !== 16'h0012) begin n_errors++; $display("FAIL halt_pc got=%h exp=0012", pc); end
    repeat (5) cyc();
    n_checks++; if (imem_req !== 1'b0) begin n_errors++; $display("FAIL halt_no_req got=%0b exp=0", imem_req); end
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0080;
    cyc();
    redirect_valid = 1'b0;
    repeat (3) cyc();
    n_checks++; if (imem_req !== 1'b0 || pc !== 16'h0012 || hlt !== 1'b1) begin
      n_errors++; $display("FAIL halt_redirect_ignored got req=%0b pc=%h hlt=%0b exp req=0 pc=0012 hlt=1", imem_req, pc, hlt);
    end
    mem[8] = 16'h1008;
  endtask

  task automatic test_halt_squash();
    bit found;
    int s0;
    mem[8] = 16'hF000;
    apply_reset(0, 100, 1'b1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc();
      if (if_valid && if_pc == 16'h0010) found = 1;
    end
    id_ready = 1'b0;
    n_checks++; if (!found) begin n_errors++; $display("FAIL hsq_find_hlt got timeout exp head pc=0010"); end
    repeat (3) cyc();
    n_checks++; if (hlt !== 1'b0 || imem_req !== 1'b0 || if_valid !== 1'b1 || if_pc !== 16'h0010) begin
      n_errors++; $display("FAIL hsq_buffered got hlt=%0b req=%0b v=%0b pc=%h exp hlt=0 req=0 v=1 pc=0010", hlt, imem_req, if_valid, if_pc);
    end
    s0 = got_pc.size();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0020;
    id_ready       = 1'b1;
    #1;
    n_checks++; if (if_valid !== 1'b0) begin n_errors++; $display("FAIL hsq_if_valid got=%0b exp=0", if_valid); end
    cyc();
    redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (imem_req) found = 1;
      else cyc();
    end
    n_checks++; if (!found || imem_addr !== 16'h0020) begin
      n_errors++; $display("FAIL hsq_resume got req=%0b addr=%h exp req=1 addr=0020", imem_req, imem_addr);
    end
    repeat (10) cyc();
    n_checks++; if (hlt !== 1'b0) begin n_errors++; $display("FAIL hsq_hlt_clear got=%0b exp=0", hlt); end
    n_checks++; if (got_pc.size() <= s0 || got_pc[s0] !== 16'h0020) begin
      n_errors++; $display("FAIL hsq_first_after got n=%0d exp pc=0020 at index %0d", got_pc.size(), s0);
    end
    mem[8] = 16'h1008;
  endtask

  task automatic test_wrap_and_reset();
    int s0;
    apply_reset(0, 100, 1'b1);
    repeat (3) cyc();
    s0 = got_pc.size();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFE;
    cyc();
    redirect_valid = 1'b0;
    repeat (10) cyc();
    n_checks++; if (got_pc.size() < s0 + 2 || got_pc[s0] !== 16'hFFFE || got_instr[s0] !== mem[15'h7FFF]) begin
      n_errors++; $display("FAIL wrap_fffe got n=%0d exp pc=FFFE instr=%h at index %0d", got_pc.size(), mem[15'h7FFF], s0);
    end else begin
      n_checks++; if (got_pc[s0 + 1] !== 16'h0000 || got_instr[s0 + 1] !== mem[0]) begin
        n_errors++; $display("FAIL wrap_zero got pc=%h instr=%h exp pc=0000 instr=%h", got_pc[s0 + 1], got_instr[s0 + 1], mem[0]);
      end
    end
    ack_lat = 6;
    repeat (3) cyc();
    n_checks++; if (imem_req !== 1'b1) begin n_errors++; $display("FAIL midwait_req got=%0b exp=1", imem_req); end
    rst_n = 1'b0;
    #1;
    n_checks++; if ({imem_req, imem_addr, if_valid, if_instr, if_pc, hlt, pc} !== 67'd0) begin
      n_errors++; $display("FAIL async_reset got req=%0b addr=%h v=%0b instr=%h ifpc=%h hlt=%0b pc=%h exp all 0",
                           imem_req, imem_addr, if_valid, if_instr, if_pc, hlt, pc);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || pc !== 16'h0000) begin
      n_errors++; $display("FAIL restart got req=%0b addr=%h pc=%h exp req=1 addr=0000 pc=0000", imem_req, imem_addr, pc);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = {4'h1, i[11:0]};
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_halt();
    test_halt_squash();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
